// File: rtl/gpio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gpio_pkg
//  Purpose  : Shared constants for the GPIO controller: register slot
//             indices (decoded from mem_addr[4:2]), width/synchroniser
//             bounds and a byte-strobe expansion helper.
//  Revision : 1.0  initial release
// ============================================================================
package gpio_pkg;

  // Register slot indices
  localparam logic [2:0] GPIO_OUT    = 3'd0;
  localparam logic [2:0] GPIO_IN     = 3'd1;
  localparam logic [2:0] GPIO_DIR    = 3'd2;
  localparam logic [2:0] GPIO_IEN    = 3'd3;
  localparam logic [2:0] GPIO_STATUS = 3'd4;
  localparam logic [2:0] GPIO_SET    = 3'd5;
  localparam logic [2:0] GPIO_CLR    = 3'd6;

  // Legal parameter ranges
  localparam int GPIO_MAX_WIDTH = 32;
  localparam int GPIO_SYNC_MIN  = 2;
  localparam int GPIO_SYNC_MAX  = 3;

  // Expand 4 byte strobes to a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
    byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gpio_sync
//  Purpose  : WIDTH-bit multi-flop synchroniser for asynchronous pad inputs,
//             followed (when GPIO_IRQ_EN is defined) by a "prev" flop used
//             for rising-edge detection.
//  Ports    : clk    in   system clock
//             reset  in   asynchronous active-high reset
//             pad    in   [WIDTH]  raw asynchronous pad inputs
//             sync   out  [WIDTH]  synchronised pad values
//             rise   out  [WIDTH]  one-cycle pulse per 0->1 transition of sync
//                                  (tied 0 when GPIO_IRQ_EN is undefined)
//  Macros   : GPIO_IRQ_EN builds the prev flop and edge detector.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_MAX_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_MIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  genvar s;
  for (s = 0; s < SYNC_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stage[s] <= '0;
        else       r_stage[s] <= pad;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stage[s] <= '0;
        else       r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign sync = r_stage[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= sync;
  end

  assign rise = sync & ~r_prev;
`else
  assign rise = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gpio_ctrl
//  Purpose  : GPIO controller on the picorv32 memory bus. Per-pin direction,
//             synchronised inputs, atomic set/clear of outputs and maskable
//             rising-edge interrupts.
//  Ports    : clk, reset          clock, asynchronous active-high reset
//             enable              chip select from address decoder
//             mem_valid/ready     bus handshake (ready high-Z when !enable)
//             mem_instr           ignored
//             mem_wstrb/wdata     byte strobes (0 = read) and write data
//             mem_addr            byte address, [4:2] selects the slot
//             mem_rdata           read data (high-Z when !enable)
//             gpio_in             asynchronous pad inputs
//             gpio_out, gpio_oe   output data and output enable
//             irq                 registered level interrupt
//  Macros   : GPIO_IRQ_EN builds IRQ_EN, STATUS and irq; otherwise slots 3/4
//             read 0 and irq is tied 0.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_instr,
  input  logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_addr,
  output logic [31:0]      mem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             r_rdy;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;

  logic [2:0]       w_idx;
  logic             w_accept;
  logic             w_wr;
  logic [31:0]      w_bmask32;
  logic [WIDTH-1:0] w_keep;
  logic [WIDTH-1:0] w_bits;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_rd_bits;
  logic [31:0]      w_rdata;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .pad   (gpio_in),
    .sync  (w_sync),
    .rise  (w_rise)
  );

  // The !r_rdy term keeps ready from asserting two cycles in a row while the
  // master is still holding mem_valid after the acknowledge.
  assign w_idx     = mem_addr[4:2];
  assign w_accept  = mem_valid & enable & ~r_rdy;
  assign w_wr      = w_accept & (|mem_wstrb);
  assign w_bmask32 = byte_mask(mem_wstrb);
  assign w_keep    = w_bmask32[WIDTH-1:0];
  assign w_bits    = mem_wdata[WIDTH-1:0] & w_keep;

  assign mem_ready = enable ? r_rdy   : 1'bz;
  assign mem_rdata = enable ? r_rdata : 32'bz;
  assign gpio_out  = r_out;
  assign gpio_oe   = r_dir;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_ien;
  logic [WIDTH-1:0] r_status;
  logic             r_irq;
  logic [WIDTH-1:0] w_w1c;

  assign w_w1c = (w_wr && w_idx == GPIO_STATUS) ? w_bits : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ien    <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_idx == GPIO_IEN) r_ien <= (r_ien & ~w_keep) | w_bits;
      // OR-ing the edge in after the clear lets a coincident edge win.
      r_status <= (r_status & ~w_w1c) | w_rise;
      r_irq    <= |(r_status & r_ien);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_bits = '0;
    case (w_idx)
      GPIO_OUT:    w_rd_bits = r_out;
      GPIO_IN:     w_rd_bits = w_sync;
      GPIO_DIR:    w_rd_bits = r_dir;
`ifdef GPIO_IRQ_EN
      GPIO_IEN:    w_rd_bits = r_ien;
      GPIO_STATUS: w_rd_bits = r_status;
`endif
      default:     w_rd_bits = '0;
    endcase
    w_rdata                = '0;
    w_rdata[WIDTH-1:0]     = w_rd_bits;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy   <= 1'b0;
      r_rdata <= '0;
      r_out   <= '0;
      r_dir   <= '0;
    end else begin
      r_rdy <= w_accept;
      if (w_accept) r_rdata <= w_rdata;
      if (w_wr) begin
        case (w_idx)
          GPIO_OUT: r_out <= (r_out & ~w_keep) | w_bits;
          GPIO_SET: r_out <= r_out | w_bits;
          GPIO_CLR: r_out <= r_out & ~w_bits;
          GPIO_DIR: r_dir <= (r_dir & ~w_keep) | w_bits;
          default:  ;
        endcase
      end
    end
  end

  // Bus bits outside the decoded range, and the edge pulses when interrupts
  // are not built.
  logic w_unused;
  assign w_unused = ^{mem_instr, mem_addr[31:5], mem_addr[1:0], mem_wdata,
                      w_bmask32, w_rise};

endmodule
`default_nettype wire

// File: doc/gpio_ctrl.md
# gpio_ctrl

- Parametrised GPIO controller for the picorv32 memory bus, successor to the fixed 32-bit output-only port.
- Adds per-pin direction control, synchronised input sampling, atomic set/clear of outputs and maskable rising-edge interrupts.
- Sits on the shared picorv32 bus behind the address decoder's `enable` line; drives pad buffers and the CPU IRQ input.

## Interface
- `WIDTH`, 32: number of GPIO pins; legal range 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth; legal range 2..3.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  chip select from the address decoder.
- `mem_valid`  in  1  bus request.
- `mem_ready`  out  1  bus acknowledge; high-Z when `enable`=0.
- `mem_instr`  in  1  instruction fetch flag; ignored.
- `mem_wstrb`  in  4  byte write strobes; all zero means read.
- `mem_wdata`  in  32  write data.
- `mem_addr`  in  32  byte address; only [4:2] decoded.
- `mem_rdata`  out  32  read data; high-Z when `enable`=0.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio_out`  out  WIDTH  output data register.
- `gpio_oe`  out  WIDTH  output enable; 1 = pin driven.
- `irq`  out  1  level interrupt, registered.

## Operation
- Register map by `mem_addr[4:2]`:
  - 0 OUT: rw.
  - 1 IN: ro, synchronised pins.
  - 2 DIR: rw.
  - 3 IRQ_EN: rw.
  - 4 IRQ_STATUS: read; write-1-to-clear.
  - 5 OUT_SET: wo; OUT |= wdata.
  - 6 OUT_CLR: wo; OUT &= ~wdata.
  - 7: reserved.
- Byte strobes qualify every write, including the set/clear/W1C bits.
- Reads of wo/reserved slots return 0; writes to ro/reserved slots are ignored.
- Bits [31:WIDTH] read 0 and are never stored.
- Input path: `gpio_in` passes through SYNC_STAGES flops, then one `prev` flop.
- Rising edge on pin i: sync[i]=1 and prev[i]=0. It sets STATUS[i] regardless of IRQ_EN.
- Edge set and W1C on the same bit in the same cycle: set wins.
- `irq` is registered: irq <= |(STATUS & IRQ_EN).
- Edges are detected on all pins, including pins configured as outputs. IN reflects the pad, not OUT.

## Timing
- Acceptance: a transaction is accepted on the edge where `mem_valid` & `enable` & !rdy.
- Write data takes effect on that same edge.
- rdy is high for exactly the following cycle. `mem_rdata` is valid in that cycle, latched at acceptance.
- Single-cycle latency; back-to-back accesses complete every second cycle.
- The master holds `mem_valid` until ready. rdy never asserts two cycles in a row.
- Pad-to-IN latency: SYNC_STAGES cycles.
- Pad-to-STATUS latency: SYNC_STAGES+1 cycles; `irq` follows one cycle later.
- Reset values: all flops 0. Concretely OUT=0, DIR=0 (all inputs), IRQ_EN=0, STATUS=0, rdy=0, `irq`=0.
- A pin high through reset release sets STATUS SYNC_STAGES+1 cycles later, but `irq` stays low because IRQ_EN=0.
- Reset asserted mid-transaction: rdy drops immediately and the write is lost; the master must restart.

## Configuration
- `GPIO_IRQ_EN` defined: prev flops, STATUS, IRQ_EN and the `irq` logic are built.
- Undefined:
  - slots 3 and 4 read 0 and ignore writes;
  - `irq` is tied 0;
  - synchronisers remain.

## Structure
- Package `gpio_pkg` holds:
  - register index constants (GPIO_OUT..GPIO_CLR);
  - max width 32;
  - SYNC_STAGES bounds.
- Sub-module `gpio_sync`: parametrised WIDTH × SYNC_STAGES synchroniser with the prev flop, outputting `sync` and `rise`.
- Bus decode, register file and `irq` live in `gpio_ctrl`.

## Test plan
- Reset, then read slots 0..7 -> all 0; `gpio_oe`=0; `irq`=0; `mem_ready`/`mem_rdata` high-Z while `enable`=0.
- Write OUT=0xA5A5_A5A5 with wstrb=0b0011, then read -> 0x0000_A5A5; write SET 0x0F00_0000 -> OUT=0x0F00_A5A5; CLR 0x0000_0005 -> 0x0F00_A5A0.
- WIDTH=8: write OUT=0xFFFF_FFFF -> read 0x0000_00FF; `gpio_out`=0xFF.
- Raise `gpio_in[3]` -> IN bit 3 after 2 cycles; STATUS=0x8 after 3 cycles; IRQ_EN=0x8 -> `irq`=1 next cycle; W1C 0x8 -> STATUS=0, `irq`=0.
- New edge on pin 3 in the same cycle as W1C of bit 3 -> STATUS[3] stays 1.
- Assert `reset` during a write's accept cycle -> rdy=0, OUT=0; build without GPIO_IRQ_EN -> `irq` stays 0 on edges.
